// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front-end with valid/take handshake and PC redirect
// One request outstanding at a time; NOP is presented whenever no fetched instruction is pending.
module inst_fetch_unit #(
    parameter int                ADDR_W  = 8,
    parameter int                INST_W  = 8,
    parameter logic [ADDR_W-1:0] RST_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memReq,
    input  logic [INST_W-1:0] memData,
    input  logic              memAck,
    output logic [INST_W-1:0] inst,
    output logic              instValid,
    input  logic              instTake,
    input  logic              jumpEn,
    input  logic [ADDR_W-1:0] jumpAddr,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] next_target;

    // Jump target wins over the sequential PC when the held instruction is consumed.
    assign next_target = jumpEn ? jumpAddr : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        mem_req_d    = mem_req_q;
        inst_valid_d = inst_valid_q;
        ir_d         = ir_q;
        case (state_q)
            ST_IDLE: begin
                state_d    = ST_REQ;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_q;
            end
            ST_REQ: begin
                if (memAck) begin
                    ir_d         = memData;
                    inst_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    pc_d         = pc_q + 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instTake) begin
                    inst_valid_d = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = next_target;
                    pc_d         = next_target;
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                mem_req_d    = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RST_VEC;
            mem_addr_q   <= RST_VEC;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            ir_q         <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
            ir_q         <= ir_d;
        end
    end

    assign memAddr   = mem_addr_q;
    assign memReq    = mem_req_q;
    assign instValid = inst_valid_q;
    assign pc        = pc_q;
    assign inst      = inst_valid_q ? ir_q : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
// Two instances share stimulus: dut uses RST_VEC=0, dut_w uses RST_VEC=8'hFF for wrap checks.
module tb_inst_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       memAck;
    logic       instTake;
    logic       jumpEn;
    logic [7:0] jumpAddr;
    logic [7:0] rom [256];

    logic [7:0] memAddr, memData, inst, pc;
    logic       memReq, instValid;
    logic [7:0] memAddr_w, memData_w, inst_w, pc_w;
    logic       memReq_w, instValid_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign memData   = rom[memAddr];
    assign memData_w = rom[memAddr_w];

    inst_fetch_unit #(.ADDR_W(8), .INST_W(8), .RST_VEC(8'h00)) dut (
        .clk(clk), .rst(rst), .memAddr(memAddr), .memReq(memReq), .memData(memData),
        .memAck(memAck), .inst(inst), .instValid(instValid), .instTake(instTake),
        .jumpEn(jumpEn), .jumpAddr(jumpAddr), .pc(pc)
    );

    inst_fetch_unit #(.ADDR_W(8), .INST_W(8), .RST_VEC(8'hFF)) dut_w (
        .clk(clk), .rst(rst), .memAddr(memAddr_w), .memReq(memReq_w), .memData(memData_w),
        .memAck(memAck), .inst(inst_w), .instValid(instValid_w), .instTake(instTake),
        .jumpEn(jumpEn), .jumpAddr(jumpAddr), .pc(pc_w)
    );

    task automatic test_reset();
        rst = 1'b0; memAck = 1'b1; instTake = 1'b1; jumpEn = 1'b0; jumpAddr = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL reset_memReq got=%b exp=0", memReq); end
        checks++; if (instValid !== 1'b0) begin failures++; $display("FAIL reset_instValid got=%b exp=0", instValid); end
        checks++; if (inst !== 8'h00) begin failures++; $display("FAIL reset_inst got=%h exp=00", inst); end
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (memAddr !== 8'h00) begin failures++; $display("FAIL reset_memAddr got=%h exp=00", memAddr); end
        checks++; if (pc_w !== 8'hFF) begin failures++; $display("FAIL reset_pc_vec got=%h exp=ff", pc_w); end
    endtask

    task automatic test_zero_wait();
        rom[0] = 8'h0B; rom[1] = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL zw_req0 got=%b exp=1", memReq); end
        checks++; if (memAddr !== 8'h00) begin failures++; $display("FAIL zw_addr0 got=%h exp=00", memAddr); end
        checks++; if (instValid !== 1'b0) begin failures++; $display("FAIL zw_valid_req0 got=%b exp=0", instValid); end
        @(negedge clk);
        checks++; if (inst !== 8'h0B) begin failures++; $display("FAIL zw_inst0 got=%h exp=0b", inst); end
        checks++; if (instValid !== 1'b1) begin failures++; $display("FAIL zw_valid0 got=%b exp=1", instValid); end
        checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL zw_req_hold got=%b exp=0", memReq); end
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL zw_pc1 got=%h exp=01", pc); end
        @(negedge clk);
        checks++; if (inst !== 8'h00) begin failures++; $display("FAIL zw_inst_nop got=%h exp=00", inst); end
        checks++; if (memAddr !== 8'h01) begin failures++; $display("FAIL zw_addr1 got=%h exp=01", memAddr); end
        checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL zw_req1 got=%b exp=1", memReq); end
        @(negedge clk);
        checks++; if (instValid !== 1'b1) begin failures++; $display("FAIL zw_valid1 got=%b exp=1", instValid); end
        checks++; if (pc !== 8'h02) begin failures++; $display("FAIL zw_pc2 got=%h exp=02", pc); end
        memAck = 1'b0;
    endtask

    task automatic test_wait_states();
        rom[2] = 8'hA5;
        instTake = 1'b1;
        @(negedge clk);
        instTake = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL ws_req[%0d] got=%b exp=1", k, memReq); end
            checks++; if (memAddr !== 8'h02) begin failures++; $display("FAIL ws_addr[%0d] got=%h exp=02", k, memAddr); end
            checks++; if (instValid !== 1'b0) begin failures++; $display("FAIL ws_valid[%0d] got=%b exp=0", k, instValid); end
            checks++; if (inst !== 8'h00) begin failures++; $display("FAIL ws_inst[%0d] got=%h exp=00", k, inst); end
            if (k == 3) memAck = 1'b1;
            @(negedge clk);
        end
        memAck = 1'b0;
        checks++; if (instValid !== 1'b1) begin failures++; $display("FAIL ws_valid_rise got=%b exp=1", instValid); end
        checks++; if (inst !== 8'hA5) begin failures++; $display("FAIL ws_inst got=%h exp=a5", inst); end
        checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL ws_req_drop got=%b exp=0", memReq); end
        checks++; if (pc !== 8'h03) begin failures++; $display("FAIL ws_pc got=%h exp=03", pc); end
    endtask

    task automatic test_jump();
        rom[8'h80] = 8'h5C;
        instTake = 1'b1; jumpEn = 1'b1; jumpAddr = 8'h80;
        @(negedge clk);
        instTake = 1'b0; jumpEn = 1'b0;
        checks++; if (memAddr !== 8'h80) begin failures++; $display("FAIL jmp_addr got=%h exp=80", memAddr); end
        checks++; if (pc !== 8'h80) begin failures++; $display("FAIL jmp_pc got=%h exp=80", pc); end
        checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL jmp_req got=%b exp=1", memReq); end
        jumpEn = 1'b1; jumpAddr = 8'h40; instTake = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (memAddr !== 8'h80) begin failures++; $display("FAIL jmp_ignored_addr got=%h exp=80", memAddr); end
        checks++; if (pc !== 8'h80) begin failures++; $display("FAIL jmp_ignored_pc got=%h exp=80", pc); end
        checks++; if (instValid !== 1'b0) begin failures++; $display("FAIL jmp_ignored_valid got=%b exp=0", instValid); end
        jumpEn = 1'b0; instTake = 1'b0; memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        checks++; if (inst !== 8'h5C) begin failures++; $display("FAIL jmp_inst got=%h exp=5c", inst); end
        checks++; if (pc !== 8'h81) begin failures++; $display("FAIL jmp_pc_next got=%h exp=81", pc); end
    endtask

    task automatic test_backpressure();
        jumpEn = 1'b1; jumpAddr = 8'h40;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (inst !== 8'h5C) begin failures++; $display("FAIL bp_inst[%0d] got=%h exp=5c", k, inst); end
            checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL bp_req[%0d] got=%b exp=0", k, memReq); end
            checks++; if (pc !== 8'h81) begin failures++; $display("FAIL bp_pc[%0d] got=%h exp=81", k, pc); end
        end
        jumpEn = 1'b0; instTake = 1'b1;
        @(negedge clk);
        instTake = 1'b0;
        checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL bp_req_resume got=%b exp=1", memReq); end
        checks++; if (memAddr !== 8'h81) begin failures++; $display("FAIL bp_addr got=%h exp=81", memAddr); end
        checks++; if (instValid !== 1'b0) begin failures++; $display("FAIL bp_valid got=%b exp=0", instValid); end
    endtask

    task automatic test_wrap_reset();
        rom[8'hFF] = 8'h3C;
        rst = 1'b0;
        #1;
        checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL mr_req_drop got=%b exp=0", memReq); end
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL mr_pc got=%h exp=00", pc); end
        checks++; if (pc_w !== 8'hFF) begin failures++; $display("FAIL mr_pc_w got=%h exp=ff", pc_w); end
        @(negedge clk);
        rst = 1'b1; memAck = 1'b1; instTake = 1'b0;
        @(negedge clk);
        checks++; if (memReq_w !== 1'b1) begin failures++; $display("FAIL wr_req got=%b exp=1", memReq_w); end
        checks++; if (memAddr_w !== 8'hFF) begin failures++; $display("FAIL wr_addr got=%h exp=ff", memAddr_w); end
        checks++; if (memAddr !== 8'h00) begin failures++; $display("FAIL mr_restart_addr got=%h exp=00", memAddr); end
        @(negedge clk);
        memAck = 1'b0;
        checks++; if (pc_w !== 8'h00) begin failures++; $display("FAIL wr_pc got=%h exp=00", pc_w); end
        checks++; if (inst_w !== 8'h3C) begin failures++; $display("FAIL wr_inst got=%h exp=3c", inst_w); end
        checks++; if (instValid_w !== 1'b1) begin failures++; $display("FAIL wr_valid got=%b exp=1", instValid_w); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'hEE;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jump();
        test_backpressure();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
